seg7_digit_driver: RTL and testbench

//   Downstream stage of the 4-digit scan selector. Takes the active-low one-hot digit_sel
//   and a 16-bit hex value, drives the anodes and cathodes of a 4-digit common-anode display.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_digit_driver.sv | 130 +++++++++++++
 tb/tb_seg7_digit_driver.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment driver.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [3:0] AN_OFF      = 4'hF;
    localparam logic [3:0] FRAME_FIRST = 4'b1110;
    localparam logic [3:0] FRAME_LAST  = 4'b0111;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex 0..F (b and d lower-case).
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // True when exactly one strobe line is low.
    function automatic logic sel_valid(input logic [3:0] s);
        return $countones(~s) == 1;
    endfunction

    // Digit position of the low strobe line; only meaningful for a valid code.
    function automatic logic [1:0] sel_index(input logic [3:0] s);
        logic [1:0] idx;
        case (s)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    // Table lookup into the shared glyph set.
    assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_digit_driver.sv
// 4-digit common-anode display driver: double-buffered value, anti-ghosting
// dead time on every strobe change, optional leading-zero blanking.
// Optional feature macro: SEG7_DP_EN adds per-digit decimal points (dp_in).
module seg7_digit_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit_sel,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        lz_blank,
`ifdef SEG7_DP_EN
    input  logic [3:0]  dp_in,
`endif
    output logic        busy,
    output logic        sel_err,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned DCNT_W  = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam bit          NO_DEAD = (DEAD_CYCLES == 0);

    state_t              state;
    logic [DCNT_W-1:0]   dcnt;
    logic [3:0]          sel_q;
    logic [15:0]         pending;
    logic [15:0]         active;
`ifdef SEG7_DP_EN
    logic [3:0]          pending_dp;
    logic [3:0]          active_dp;
`endif

    logic                sel_ok;
    logic                sel_q_ok;
    logic                change;
    logic                commit;
    logic                lz_hit;
    logic [1:0]          idx;
    logic [3:0]          nibble;
    logic [6:0]          hex_seg_c;

    // Strobe qualification, frame boundary and digit content selection.
    always_comb begin
        sel_ok   = sel_valid(digit_sel);
        sel_q_ok = sel_valid(sel_q);
        change   = (digit_sel != sel_q);
        commit   = (sel_q == FRAME_LAST) && (digit_sel == FRAME_FIRST);
        idx      = sel_index(sel_q);
        nibble   = active[{idx, 2'b00} +: 4];
        lz_hit   = lz_blank && (idx != 2'd0) && ((active >> {idx, 2'b00}) == 16'h0000);
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg_c  (hex_seg_c)
    );

    // Buffers, blank/show FSM with dead-time counter, and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= AN_OFF;
            state   <= BLANK;
            dcnt    <= DCNT_W'(DEAD_CYCLES);
            pending <= '0;
            active  <= '0;
            busy    <= 1'b0;
            sel_err <= 1'b0;
            an      <= AN_OFF;
            seg     <= SEG_BLANK;
`ifdef SEG7_DP_EN
            pending_dp <= '0;
            active_dp  <= '0;
            dp         <= 1'b1;
`endif
        end else begin
            sel_q   <= digit_sel;
            sel_err <= ~sel_ok & change;

            if (commit) begin
                active <= pending;
`ifdef SEG7_DP_EN
                active_dp <= pending_dp;
`endif
            end

            if (load) begin
                pending <= value_in;
`ifdef SEG7_DP_EN
                pending_dp <= dp_in;
`endif
                busy    <= 1'b1;
            end else if (commit) begin
                busy <= 1'b0;
            end

            an  <= AN_OFF;
            seg <= SEG_BLANK;
`ifdef SEG7_DP_EN
            dp  <= 1'b1;
`endif

            if (!sel_ok || (change && !NO_DEAD)) begin
                state <= BLANK;
                dcnt  <= DCNT_W'(DEAD_CYCLES);
            end else if (state == SHOW || dcnt <= DCNT_W'(1)) begin
                state <= SHOW;
                dcnt  <= '0;
                if (sel_q_ok) begin
                    an  <= sel_q;
                    seg <= lz_hit ? SEG_BLANK : hex_seg_c;
`ifdef SEG7_DP_EN
                    dp  <= ~active_dp[idx];
`endif
                end
            end else begin
                dcnt <= dcnt - DCNT_W'(1);
            end
        end
    end

`ifndef SEG7_DP_EN
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_digit_driver.sv
// Self-checking bench for seg7_digit_driver (optionally built with SEG7_DP_EN).
`timescale 1ns/1ps
module tb_seg7_digit_driver;

    localparam int DEAD = 2;
`ifdef SEG7_DP_EN
    localparam bit DP_ON = 1'b1;
`else
    localparam bit DP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digit_sel = 4'hF;
    logic [15:0] value_in = 16'h0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
`ifdef SEG7_DP_EN
    logic [3:0]  dp_in = 4'h0;
`endif
    logic        busy;
    logic        sel_err;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // Lit segments as active-high {g,f,e,d,c,b,a}; display wants the inverse.
    logic [6:0] on_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg7_digit_driver #(.DEAD_CYCLES(DEAD)) dut (
        .clk       (clk),
        .rst       (rst),
        .digit_sel (digit_sel),
        .value_in  (value_in),
        .load      (load),
        .lz_blank  (lz_blank),
`ifdef SEG7_DP_EN
        .dp_in     (dp_in),
`endif
        .busy      (busy),
        .sel_err   (sel_err),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit one_zero(input logic [3:0] s);
        int n = 0;
        for (int k = 0; k < 4; k++) if (!s[k]) n++;
        return n == 1;
    endfunction

    function automatic int zero_pos(input logic [3:0] s);
        for (int k = 0; k < 4; k++) if (!s[k]) return k;
        return 0;
    endfunction

    // Reference model: a digit lights once its strobe has been steady for DEAD+1 edges.
    logic [3:0]  m_prev;
    int          m_run;
    logic [15:0] m_pend, m_act;
    logic [3:0]  m_pdp, m_adp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_busy, exp_err;

    always @(posedge clk or posedge rst) begin : model
        logic [3:0] d;
        logic [3:0] nib;
        int         run;
        int         i;
        bit         show;
        bit         lz;
        bit         cm;
        if (rst) begin
            m_prev   <= 4'hF;
            m_run    <= 0;
            m_pend   <= 16'h0;
            m_act    <= 16'h0;
            m_pdp    <= 4'h0;
            m_adp    <= 4'h0;
            exp_an   <= 4'hF;
            exp_seg  <= 7'h7F;
            exp_dp   <= 1'b1;
            exp_busy <= 1'b0;
            exp_err  <= 1'b0;
        end else begin
            d    = digit_sel;
            run  = (d == m_prev) ? m_run + 1 : 1;
            if (run > 1000) run = 1000;
            show = one_zero(d) && one_zero(m_prev) && (DEAD == 0 || run >= DEAD + 1);
            i    = zero_pos(m_prev);
            nib  = 4'((m_act >> (4 * i)) & 16'hF);
            lz   = lz_blank && (i > 0) && ((m_act >> (4 * i)) == 16'h0);
            cm   = (m_prev == 4'b0111) && (d == 4'b1110);

            exp_an  <= show ? m_prev : 4'hF;
            exp_seg <= (!show || lz) ? 7'h7F : ~on_tab[nib];
            exp_dp  <= (show && DP_ON) ? ~m_adp[i] : 1'b1;
            exp_err <= !one_zero(d) && (d != m_prev);

            if (cm) begin
                m_act <= m_pend;
                m_adp <= m_pdp;
            end
            if (load) begin
                m_pend   <= value_in;
`ifdef SEG7_DP_EN
                m_pdp    <= dp_in;
`endif
                exp_busy <= 1'b1;
            end else if (cm) begin
                exp_busy <= 1'b0;
            end
            m_prev <= d;
            m_run  <= run;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_an", 16'(an), 16'(exp_an));
            check("cyc_seg", 16'(seg), 16'(exp_seg));
            check("cyc_dp", 16'(dp), 16'(exp_dp));
            check("cyc_busy", 16'(busy), 16'(exp_busy));
            check("cyc_sel_err", 16'(sel_err), 16'(exp_err));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic show_digit(input int k, input int n);
        digit_sel = rot[k];
        repeat (n) cyc();
    endtask

    task automatic show_check(input string name, input int k, input logic [6:0] s);
        show_digit(k, 8);
        check({name, "_an"}, 16'(an), 16'(rot[k]));
        check({name, "_seg"}, 16'(seg), 16'(s));
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int pos;
        int hold;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) cyc();
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_dp", 16'(dp), 16'h1);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_sel_err", 16'(sel_err), 16'h0);
        rst = 1'b0;

        // Load 1234 and scan; commit happens at the first 0111 -> 1110 step.
        value_in = 16'h1234;
`ifdef SEG7_DP_EN
        dp_in = 4'b0010;
`endif
        load = 1'b1;
        cyc();
        load = 1'b0;
        check("load_busy", 16'(busy), 16'h1);
        for (int k = 0; k < 4; k++) show_digit(k, 8);
        digit_sel = rot[0];
        cyc();
        check("commit_busy", 16'(busy), 16'h0);
        check("dead1_an", 16'(an), 16'hF);
        cyc();
        check("dead2_an", 16'(an), 16'hF);
        check("dead2_seg", 16'(seg), 16'h7F);
        cyc();
        check("d0_an", 16'(an), 16'hE);
        check("d0_seg4", 16'(seg), 16'h19);
        repeat (5) cyc();
        check("d0_dp", 16'(dp), 16'h1);
        show_check("d1_3", 1, 7'h30);
        check("d1_dp", 16'(dp), DP_ON ? 16'h0 : 16'h1);
        show_check("d2_2", 2, 7'h24);
        show_check("d3_1", 3, 7'h79);

        // Load ABCD mid-frame; display holds until the frame boundary.
        show_check("f2_d0", 0, 7'h19);
        show_check("f2_d1", 1, 7'h30);
        digit_sel = rot[2];
        repeat (4) cyc();
        value_in = 16'hABCD;
        load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (3) cyc();
        check("abcd_busy", 16'(busy), 16'h1);
        check("abcd_hold_seg", 16'(seg), 16'h24);
        show_check("abcd_hold_d3", 3, 7'h79);
        show_check("abcd_d0", 0, 7'h21);
        check("abcd_busy_clr", 16'(busy), 16'h0);
        show_check("abcd_d1", 1, 7'h46);
        show_check("abcd_d2", 2, 7'h03);
        show_check("abcd_d3", 3, 7'h08);

        // Two loads in one frame: only the second is ever shown.
        show_digit(0, 8);
        digit_sel = rot[1];
        repeat (2) cyc();
        value_in = 16'h1111;
        load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (2) cyc();
        value_in = 16'h2222;
        load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (2) cyc();
        show_digit(2, 8);
        show_digit(3, 8);
        for (int k = 0; k < 4; k++) show_check("two_load", k, 7'h24);

        // Leading-zero blanking.
        lz_blank = 1'b1;
        value_in = 16'h0007;
        load = 1'b1;
        cyc();
        load = 1'b0;
        show_check("lz7_d0", 0, 7'h78);
        show_check("lz7_d1", 1, 7'h7F);
        show_check("lz7_d2", 2, 7'h7F);
        show_check("lz7_d3", 3, 7'h7F);
        value_in = 16'h0000;
        load = 1'b1;
        cyc();
        load = 1'b0;
        show_check("lz0_d0", 0, 7'h40);
        show_check("lz0_d1", 1, 7'h7F);

        // Invalid strobe: single error pulse, anodes off, then recovery.
        digit_sel = 4'b1100;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (sel_err) pulses++;
            check("inv_an", 16'(an), 16'hF);
        end
        check("inv_pulses", 16'(pulses), 16'd1);
        digit_sel = rot[2];
        cyc();
        check("rec1_an", 16'(an), 16'hF);
        cyc();
        check("rec2_an", 16'(an), 16'hF);
        cyc();
        check("rec3_an", 16'(an), 16'hB);
        show_digit(3, 8);
        lz_blank = 1'b0;

        // Randomized scanning, loads, glitches and leading-zero toggling.
        pos = 3;
        for (int it = 0; it < 2000; it++) begin
            if ($urandom_range(0, 99) < 85) begin
                pos = (pos + 1) % 4;
                digit_sel = rot[pos];
            end else begin
                digit_sel = 4'($urandom_range(0, 15));
            end
            hold = $urandom_range(1, 10);
            for (int c = 0; c < hold; c++) begin
                load = ($urandom_range(0, 7) == 0);
                value_in = 16'($urandom);
`ifdef SEG7_DP_EN
                dp_in = 4'($urandom);
`endif
                if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
                cyc();
            end
        end
        load = 1'b0;
        lz_blank = 1'b0;

        // Reset while showing with a load pending.
        show_digit(0, 8);
        value_in = 16'h5555;
        load = 1'b1;
        cyc();
        load = 1'b0;
        check("pre_rst_busy", 16'(busy), 16'h1);
        cyc();
        rst = 1'b1;
        #1;
        check("midrst_an", 16'(an), 16'hF);
        check("midrst_seg", 16'(seg), 16'h7F);
        check("midrst_busy", 16'(busy), 16'h0);
        check("midrst_dp", 16'(dp), 16'h1);
        repeat (2) cyc();
        rst = 1'b0;
        show_check("post_rst_d0", 0, 7'h40);
        check("post_rst_busy", 16'(busy), 16'h0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
